// File: rtl/sine_phase_tracker.sv
// sine_phase_tracker: recovers period, lock, per-sample phase increment and an 8-bit phase from an offset-binary sine stream.
// Define SINE_TRACK_HYST_EN to apply +/-HYST hysteresis around the midpoint; otherwise thresholds sit exactly at 128/127.
module sine_phase_tracker #(
    parameter int HYST     = 4,
    parameter int LOCK_TOL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [7:0]  sample,
    output logic        rising,
    output logic [15:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic [15:0] phase_inc,
    output logic        inc_valid,
    output logic [7:0]  phase
);

`ifdef SINE_TRACK_HYST_EN
    localparam int H = HYST;
`else
    localparam int H = 0 * HYST;
`endif
    localparam logic [8:0]  ABOVE_TH = 9'(128 + H);
    localparam logic [8:0]  BELOW_TH = 9'(127 - H);
    localparam logic [15:0] TOL      = 16'(LOCK_TOL);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} level_e;

    level_e      state_q, state_d;
    logic        have_ref_q, have_ref_d;
    logic        have_prev_q, have_prev_d;
    logic [15:0] count_q, count_d;
    logic        rising_q, rising_d;
    logic [15:0] period_q, period_d;
    logic        period_valid_q, period_valid_d;
    logic        locked_q, locked_d;
    logic [15:0] phase_inc_q, phase_inc_d;
    logic        inc_valid_q, inc_valid_d;
    logic        inc_ok_q, inc_ok_d;
    logic [15:0] acc_q, acc_d;
    logic        div_busy_q, div_busy_d;
    logic [4:0]  div_iter_q, div_iter_d;
    logic [15:0] div_rem_q, div_rem_d;
    logic [16:0] div_quo_q, div_quo_d;
    logic [15:0] div_den_q, div_den_d;

    logic        above, below, rise, sat;
    logic [15:0] period_new, period_diff;
    logic [16:0] rem_shift;
    logic        rem_fits;

    assign above       = {1'b0, sample} >= ABOVE_TH;
    assign below       = {1'b0, sample} <= BELOW_TH;
    assign rise        = sample_valid && (state_q == LOW) && above;
    assign sat         = sample_valid && have_ref_q && (count_q == 16'hFFFF);
    assign period_new  = count_q + 16'd1;
    assign period_diff = (period_new >= period_q) ? (period_new - period_q) : (period_q - period_new);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            have_ref_q     <= 1'b0;
            have_prev_q    <= 1'b0;
            count_q        <= '0;
            rising_q       <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            phase_inc_q    <= '0;
            inc_valid_q    <= 1'b0;
            inc_ok_q       <= 1'b0;
            acc_q          <= '0;
            div_busy_q     <= 1'b0;
            div_iter_q     <= '0;
            div_rem_q      <= '0;
            div_quo_q      <= '0;
            div_den_q      <= '0;
        end else begin
            state_q        <= state_d;
            have_ref_q     <= have_ref_d;
            have_prev_q    <= have_prev_d;
            count_q        <= count_d;
            rising_q       <= rising_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            phase_inc_q    <= phase_inc_d;
            inc_valid_q    <= inc_valid_d;
            inc_ok_q       <= inc_ok_d;
            acc_q          <= acc_d;
            div_busy_q     <= div_busy_d;
            div_iter_q     <= div_iter_d;
            div_rem_q      <= div_rem_d;
            div_quo_q      <= div_quo_d;
            div_den_q      <= div_den_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sample_valid) begin
            case (state_q)
                IDLE:    if (above) state_d = HIGH; else if (below) state_d = LOW;
                LOW:     if (above) state_d = HIGH;
                HIGH:    if (below) state_d = LOW;
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturation is applied first so a crossing on the same sample falls into the new-reference path.
    always_comb begin
        have_ref_d     = have_ref_q;
        have_prev_d    = have_prev_q;
        count_d        = count_q;
        period_d       = period_q;
        locked_d       = locked_q;
        period_valid_d = 1'b0;
        rising_d       = rise;
        if (sample_valid && have_ref_q) count_d = count_q + 16'd1;
        if (sat) begin
            have_ref_d  = 1'b0;
            have_prev_d = 1'b0;
            locked_d    = 1'b0;
            count_d     = '0;
        end
        if (rise) begin
            count_d = '0;
            if (!have_ref_q || sat) begin
                have_ref_d  = 1'b1;
                have_prev_d = 1'b0;
                locked_d    = 1'b0;
            end else begin
                period_d       = period_new;
                period_valid_d = 1'b1;
                have_prev_d    = 1'b1;
                locked_d       = have_prev_q && (period_diff <= TOL);
            end
        end
    end

    // Restoring divide of 2^16 by the period; the dividend's only set bit enters on iteration 0.
    always_comb begin
        div_busy_d  = div_busy_q;
        div_iter_d  = div_iter_q;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        div_den_d   = div_den_q;
        phase_inc_d = phase_inc_q;
        inc_valid_d = 1'b0;
        inc_ok_d    = inc_ok_q;
        rem_shift   = {div_rem_q, (div_iter_q == 5'd0)};
        rem_fits    = rem_shift >= {1'b0, div_den_q};
        if (period_valid_q) begin
            div_busy_d = 1'b1;
            div_iter_d = '0;
            div_rem_d  = '0;
            div_quo_d  = '0;
            div_den_d  = period_q;
        end else if (div_busy_q) begin
            div_rem_d  = rem_fits ? 16'(rem_shift - {1'b0, div_den_q}) : rem_shift[15:0];
            div_quo_d  = {div_quo_q[15:0], rem_fits};
            div_iter_d = div_iter_q + 5'd1;
            if (div_iter_q == 5'd16) begin
                div_busy_d  = 1'b0;
                inc_valid_d = 1'b1;
                inc_ok_d    = 1'b1;
                phase_inc_d = div_quo_d[16] ? 16'hFFFF : div_quo_d[15:0];
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (rise) acc_d = '0;
        else if (sample_valid && inc_ok_q) acc_d = acc_q + phase_inc_q;
    end

    assign rising       = rising_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign phase_inc    = phase_inc_q;
    assign inc_valid    = inc_valid_q;
    assign phase        = acc_q[15:8];

endmodule

// File: tb/tb_sine_phase_tracker.sv
// tb_sine_phase_tracker: randomized self-checking bench for sine_phase_tracker against an index-based reference model.
// Honours SINE_TRACK_HYST_EN the same way the design does.
module tb_sine_phase_tracker;

    localparam int HYST     = 4;
    localparam int LOCK_TOL = 2;
`ifdef SINE_TRACK_HYST_EN
    localparam int H = HYST;
`else
    localparam int H = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample = 8'd0;
    logic        rising, period_valid, locked, inc_valid;
    logic [15:0] period, phase_inc;
    logic [7:0]  phase;
    logic [43:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sine_phase_tracker #(.HYST(HYST), .LOCK_TOL(LOCK_TOL)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .rising(rising), .period(period), .period_valid(period_valid), .locked(locked),
        .phase_inc(phase_inc), .inc_valid(inc_valid), .phase(phase)
    );

    assign dut_vec = {rising, period_valid, locked, inc_valid, period, phase_inc, phase};

    // Reference model: crossings are located by valid-sample index, periods are index differences,
    // and each increment is 65536/period delivered 18 clocks after its period report unless superseded.
    int          m_cyc = 0, m_vidx = 0, m_ref_vidx = 0, m_side = 0, m_pend_at = 0, m_p = 0;
    bit          m_has_ref = 0, m_have_prev = 0, m_inc_ok = 0, m_pend = 0;
    bit          m_above, m_below, m_cross, m_old_ok;
    logic [15:0] m_acc = '0, m_old_inc, m_pend_val = '0;
    logic        exp_rising = 0, exp_pv = 0, exp_locked = 0, exp_iv = 0;
    logic [15:0] exp_period = '0, exp_inc = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_vidx = 0; m_ref_vidx = 0; m_side = 0; m_pend = 0;
            m_has_ref = 0; m_have_prev = 0; m_inc_ok = 0; m_acc = '0;
            exp_rising = 0; exp_pv = 0; exp_locked = 0; exp_iv = 0;
            exp_period = '0; exp_inc = '0;
        end else begin
            m_cyc++;
            exp_rising = 0; exp_pv = 0; exp_iv = 0;
            m_old_inc = exp_inc;
            m_old_ok  = m_inc_ok;
            if (m_pend && m_cyc == m_pend_at) begin
                exp_iv = 1; exp_inc = m_pend_val; m_inc_ok = 1; m_pend = 0;
            end
            if (sample_valid) begin
                m_above = int'(sample) >= 128 + H;
                m_below = int'(sample) <= 127 - H;
                m_cross = (m_side == 1) && m_above;
                m_vidx++;
                if (m_cross) m_acc = '0;
                else if (m_old_ok) m_acc = m_acc + m_old_inc;
                if (m_has_ref && (m_vidx - m_ref_vidx) >= 65536) begin
                    m_has_ref = 0; m_have_prev = 0; exp_locked = 0;
                end
                if (m_cross) begin
                    exp_rising = 1;
                    if (!m_has_ref) begin
                        m_has_ref = 1; m_have_prev = 0; exp_locked = 0;
                    end else begin
                        m_p = m_vidx - m_ref_vidx;
                        exp_locked = m_have_prev &&
                                     ((m_p - int'(exp_period)) <= LOCK_TOL) &&
                                     ((int'(exp_period) - m_p) <= LOCK_TOL);
                        exp_period  = 16'(m_p);
                        m_have_prev = 1;
                        exp_pv      = 1;
                        m_pend      = 1;
                        m_pend_at   = m_cyc + 18;
                        m_pend_val  = (65536 / m_p > 65535) ? 16'hFFFF : 16'(65536 / m_p);
                    end
                    m_ref_vidx = m_vidx;
                end
                if (m_above) m_side = 2;
                else if (m_below) m_side = 1;
            end
        end
    end

    function automatic logic [43:0] model_vec();
        return {exp_rising, exp_pv, exp_locked, exp_iv, exp_period, exp_inc, m_acc[15:8]};
    endfunction

    function automatic logic [7:0] sine_of(input logic [7:0] ph);
        real r;
        r = 128.0 + 127.0 * $sin(6.283185307179586 * real'(ph) / 256.0);
        return 8'($rtoi(r + 0.5));
    endfunction

    task automatic apply_stimulus(input logic v, input logic [7:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (dut_vec !== 44'h0) begin
            n_fail++; $display("[TB] FAIL reset_power_on got=%h exp=%h", dut_vec, 44'h0);
        end
        do_reset();
    endtask

    task automatic test_sine_lock();
        logic [7:0] ph, off, d;
        int rises, pvs, last_pv;
        bit seen_inc, armed;
        do_reset();
        ph = 0; off = 0; rises = 0; pvs = 0; last_pv = -100; seen_inc = 0; armed = 0;
        for (int i = 0; i < 384; i++) begin
            apply_stimulus(1'b1, sine_of(ph));
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("[TB] FAIL sine_model i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (armed) begin
                d = ph - phase - off;
                n_checks++;
                if (!(d == 8'd0 || d == 8'd1 || d == 8'hFF)) begin
                    n_fail++; $display("[TB] FAIL sine_phase_offset i=%0d phase=%0d gen=%0d offset=%0d", i, phase, ph, off);
                end
            end
            if (period_valid) begin
                pvs++; last_pv = i;
                n_checks++;
                if (period !== 16'd64) begin
                    n_fail++; $display("[TB] FAIL sine_period got=%0d exp=64", period);
                end
            end
            if (inc_valid) begin
                seen_inc = 1;
                n_checks++;
                if (phase_inc !== 16'd1024 || i - last_pv != 18) begin
                    n_fail++; $display("[TB] FAIL sine_inc got=%0d after %0d clocks exp=1024 after 18", phase_inc, i - last_pv);
                end
            end
            if (rising) begin
                rises++;
                n_checks++;
                if (locked !== (rises >= 3)) begin
                    n_fail++; $display("[TB] FAIL sine_locked crossing=%0d got=%b exp=%b", rises, locked, rises >= 3);
                end
                if (seen_inc) begin armed = 1; off = ph - phase; end
            end
            ph += 8'd4;
        end
        n_checks++;
        if (rises != 5 || pvs != 4) begin
            n_fail++; $display("[TB] FAIL sine_counts rising=%0d pv=%0d exp 5 and 4", rises, pvs);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, sine_of(8'(i * 4)));
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("[TB] FAIL midreset_pre got=%h exp=%h", dut_vec, model_vec());
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== 44'h0) begin
            n_fail++; $display("[TB] FAIL midreset_async got=%h exp=%h", dut_vec, 44'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 8'($urandom_range(200, 255)));
            n_checks++;
            if (rising !== 1'b0 || dut_vec !== model_vec()) begin
                n_fail++; $display("[TB] FAIL midreset_no_rise got=%h exp=%h", dut_vec, model_vec());
            end
        end
        apply_stimulus(1'b1, 8'd0);
        apply_stimulus(1'b1, 8'd255);
        n_checks++;
        if (rising !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midreset_first_rise got=%b exp=1", rising);
        end
    endtask

    task automatic test_alternating();
        int rises, pvs;
        do_reset();
        rises = 0; pvs = 0;
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'b1, (i % 2 == 0) ? 8'd126 : 8'd130);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("[TB] FAIL alt_model i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (rising) rises++;
            if (period_valid) pvs++;
        end
        for (int i = 0; i < 25; i++) apply_stimulus(1'b0, 8'($urandom));
`ifdef SINE_TRACK_HYST_EN
        n_checks++;
        if (rises != 0 || pvs != 0 || period !== 16'd0) begin
            n_fail++; $display("[TB] FAIL alt_deadband rising=%0d pv=%0d period=%0d exp all 0", rises, pvs, period);
        end
`else
        n_checks++;
        if (rises != 20 || pvs != 19 || period !== 16'd2 || phase_inc !== 16'd32768) begin
            n_fail++; $display("[TB] FAIL alt_nohyst rising=%0d pv=%0d period=%0d inc=%0d exp 20 19 2 32768", rises, pvs, period, phase_inc);
        end
`endif
    endtask

    task automatic test_period_switch();
        logic [7:0] ph;
        int n32;
        do_reset();
        ph = 0; n32 = 0;
        for (int i = 0; i < 384; i++) begin
            apply_stimulus(1'b1, sine_of(ph));
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("[TB] FAIL switch_model i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (period_valid && period == 16'd32) begin
                n32++;
                n_checks++;
                if (locked !== (n32 >= 2)) begin
                    n_fail++; $display("[TB] FAIL switch_locked n32=%0d got=%b exp=%b", n32, locked, n32 >= 2);
                end
            end
            ph += (i < 255) ? 8'd4 : 8'd8;
        end
        n_checks++;
        if (phase_inc !== 16'd2048 || period !== 16'd32 || locked !== 1'b1) begin
            n_fail++; $display("[TB] FAIL switch_final inc=%0d period=%0d locked=%b exp 2048 32 1", phase_inc, period, locked);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [17];
        int incs;
        do_reset();
        incs = 0;
        foreach (seq[k]) seq[k] = 8'd0;
        seq[1] = 8'd255; seq[11] = 8'd255; seq[16] = 8'd255;
        for (int i = 0; i < 17 + 30; i++) begin
            apply_stimulus(1'b1, (i < 17) ? seq[i] : 8'd0);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("[TB] FAIL b2b_model i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (inc_valid) incs++;
        end
        n_checks++;
        if (incs != 1 || phase_inc !== 16'd13107 || period !== 16'd5) begin
            n_fail++; $display("[TB] FAIL b2b_restart inc_valid=%0d inc=%0d period=%0d exp 1 13107 5", incs, phase_inc, period);
        end
    endtask

    task automatic test_valid_gaps();
        logic [7:0] ph, prev;
        int nvalid;
        bit v;
        do_reset();
        ph = 0; nvalid = 0;
        for (int i = 0; i < 2000 && nvalid < 384; i++) begin
            v = ($urandom_range(0, 99) < 65);
            prev = phase;
            if (v) begin
                apply_stimulus(1'b1, sine_of(ph));
                ph += 8'd4;
                nvalid++;
            end else begin
                apply_stimulus(1'b0, 8'($urandom));
                n_checks++;
                if (phase !== prev) begin
                    n_fail++; $display("[TB] FAIL gaps_frozen got=%0d exp=%0d", phase, prev);
                end
            end
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("[TB] FAIL gaps_model i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (period_valid) begin
                n_checks++;
                if (period !== 16'd64) begin
                    n_fail++; $display("[TB] FAIL gaps_period got=%0d exp=64", period);
                end
            end
        end
        n_checks++;
        if (phase_inc !== 16'd1024) begin
            n_fail++; $display("[TB] FAIL gaps_inc got=%0d exp=1024", phase_inc);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] ph;
        do_reset();
        ph = 0;
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(1'b1, sine_of(ph));
            ph += 8'd4;
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("[TB] FAIL sat_prelock got=%b exp=1", locked);
        end
        for (int i = 0; i < 65600; i++) begin
            apply_stimulus(1'b1, 8'd200);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("[TB] FAIL sat_model i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++; $display("[TB] FAIL sat_unlock got=%b exp=0", locked);
        end
        apply_stimulus(1'b1, 8'd0);
        apply_stimulus(1'b1, 8'd255);
        n_checks++;
        if (rising !== 1'b1 || period_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL sat_new_ref rising=%b pv=%b exp 1 0", rising, period_valid);
        end
        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 8'd0);
        apply_stimulus(1'b1, 8'd255);
        n_checks++;
        if (period_valid !== 1'b1 || period !== 16'd10 || dut_vec !== model_vec()) begin
            n_fail++; $display("[TB] FAIL sat_next_period pv=%b period=%0d exp 1 10", period_valid, period);
        end
    endtask

    initial begin
        $display("[TB] sine_phase_tracker bench, hysteresis half-width %0d", H);
        test_reset();
        test_sine_lock();
        test_reset_midstream();
        test_alternating();
        test_period_switch();
        test_back_to_back();
        test_valid_gaps();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
